// File: rtl/sysbus_mem_responder_if.sv
// SysBus signal bundle between the datapath (master) and the memory responder (slave).
interface sysbus_mem_responder_if;
   logic [15:0] SysBus;
   logic        ALE;
   logic        Read;
   logic        Write;
   logic [15:0] DataIn;
   logic        MemRdy;
   logic        BusErr;

   modport master (
      output SysBus, ALE, Read, Write,
      input  DataIn, MemRdy, BusErr
   );

   modport slave (
      input  SysBus, ALE, Read, Write,
      output DataIn, MemRdy, BusErr
   );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Memory-side SysBus responder: latches an address, then services one read or write
// from a local synchronous RAM after a programmable number of wait states.
//
// state | meaning
// IDLE  | no transfer, waiting for ALE
// ADDR  | address latched, waiting for Read/Write (ALE re-latches)
// WAIT  | wait-state countdown before the RAM access
// DONE  | access performed on entry edge, MemRdy high
module sysbus_mem_responder #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 1
) (
   input logic                  Clock,
   input logic                  nReset,
   sysbus_mem_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t                state, state_next;
   logic [ADDR_BITS-1:0]  addr, addr_next;
   logic [15:0]           wdata, wdata_next;
   logic                  op_wr, op_wr_next;
   logic [3:0]            cnt, cnt_next;
   logic [15:0]           data_in;
   logic                  mem_rdy, bus_err;
   logic                  acc_go, acc_wr, err_next;
   logic [15:0]           acc_wdata;
   logic [15:0]           mem [2**ADDR_BITS];

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state   <= IDLE;
         addr    <= '0;
         wdata   <= '0;
         op_wr   <= 1'b0;
         cnt     <= '0;
         data_in <= '0;
         mem_rdy <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state   <= state_next;
         addr    <= addr_next;
         wdata   <= wdata_next;
         op_wr   <= op_wr_next;
         cnt     <= cnt_next;
         mem_rdy <= (state_next == DONE);
         bus_err <= err_next;
         if (acc_go && !acc_wr)
            data_in <= mem[addr];
      end
   end

   always_comb begin
      state_next = state;
      addr_next  = addr;
      wdata_next = wdata;
      op_wr_next = op_wr;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (bus.ALE) begin
               addr_next  = bus.SysBus[ADDR_BITS-1:0];
               state_next = ADDR;
            end
         end
         ADDR: begin
            if (bus.ALE) begin
               addr_next = bus.SysBus[ADDR_BITS-1:0];
            end else if (bus.Write || bus.Read) begin
               op_wr_next = bus.Write;
               if (bus.Write)
                  wdata_next = bus.SysBus;
               if (WAIT_STATES == 0) begin
                  state_next = DONE;
               end else begin
                  cnt_next   = CNT_INIT;
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0)
               state_next = DONE;
            else
               cnt_next = cnt - 4'd1;
         end
         DONE: begin
            if (bus.ALE) begin
               addr_next  = bus.SysBus[ADDR_BITS-1:0];
               state_next = ADDR;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // With zero wait states the access edge is the command edge, so the op and
   // write data come straight off the bus rather than from their registers.
   always_comb begin
      acc_go    = (state_next == DONE) && (state != DONE);
      acc_wr    = (state == ADDR) ? bus.Write : op_wr;
      acc_wdata = (state == ADDR) ? bus.SysBus : wdata;
      err_next  = (state == ADDR) && !bus.ALE && bus.Read && bus.Write;
   end

   always_ff @(posedge Clock) begin
      if (acc_go && acc_wr)
         mem[addr] <= acc_wdata;
   end

   assign bus.DataIn = data_in;
   assign bus.MemRdy = mem_rdy;
   assign bus.BusErr = bus_err;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: three instances (0, 1 and 3 wait states)
// share one stimulus; the monitor checks the instance currently selected.
module tb_sysbus_mem_responder;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   logic        clk;
   logic        nreset;
   logic [15:0] sys_bus;
   logic        ale, rd, wr;
   int          sel;
   int          cyc;
   int          tests, fails;
   bit          mon_en;

   exp_t        rdy_q[$];
   int          err_q[$];
   exp_t        mon_e;
   int          mon_c;

   logic [15:0] ram_m [1024];
   logic [9:0]  cur_addr;
   logic [15:0] exp_din;

   logic [15:0] din_s;
   logic        rdy_s, err_s;

   sysbus_mem_responder_if if0 ();
   sysbus_mem_responder_if if1 ();
   sysbus_mem_responder_if if3 ();

   assign if0.SysBus = sys_bus;  assign if0.ALE = ale;  assign if0.Read = rd;  assign if0.Write = wr;
   assign if1.SysBus = sys_bus;  assign if1.ALE = ale;  assign if1.Read = rd;  assign if1.Write = wr;
   assign if3.SysBus = sys_bus;  assign if3.ALE = ale;  assign if3.Read = rd;  assign if3.Write = wr;

   sysbus_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (.Clock(clk), .nReset(nreset), .bus(if0.slave));
   sysbus_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(1)) dut1 (.Clock(clk), .nReset(nreset), .bus(if1.slave));
   sysbus_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(3)) dut3 (.Clock(clk), .nReset(nreset), .bus(if3.slave));

   always_comb begin
      din_s = if1.DataIn;
      rdy_s = if1.MemRdy;
      err_s = if1.BusErr;
      if (sel == 0) begin
         din_s = if0.DataIn;
         rdy_s = if0.MemRdy;
         err_s = if0.BusErr;
      end else if (sel == 3) begin
         din_s = if3.DataIn;
         rdy_s = if3.MemRdy;
         err_s = if3.BusErr;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rdy_s) begin
            tests++;
            if (rdy_q.size() == 0) begin
               fails++;
               $display("FAIL memrdy_unexpected cyc=%0d got MemRdy=1 required 0", cyc);
            end else begin
               mon_e = rdy_q.pop_front();
               if (mon_e.cyc != cyc || din_s !== mon_e.data) begin
                  fails++;
                  $display("FAIL memrdy_data got cyc=%0d DataIn=%h required cyc=%0d DataIn=%h",
                           cyc, din_s, mon_e.cyc, mon_e.data);
               end
            end
         end
         while (rdy_q.size() > 0 && rdy_q[0].cyc < cyc) begin
            mon_e = rdy_q.pop_front();
            tests++;
            fails++;
            $display("FAIL memrdy_missing got none required MemRdy at cyc=%0d", mon_e.cyc);
         end
         if (err_s) begin
            tests++;
            if (err_q.size() == 0) begin
               fails++;
               $display("FAIL buserr_unexpected cyc=%0d got BusErr=1 required 0", cyc);
            end else begin
               mon_c = err_q.pop_front();
               if (mon_c != cyc) begin
                  fails++;
                  $display("FAIL buserr_timing got cyc=%0d required cyc=%0d", cyc, mon_c);
               end
            end
         end
         while (err_q.size() > 0 && err_q[0] < cyc) begin
            mon_c = err_q.pop_front();
            tests++;
            fails++;
            $display("FAIL buserr_missing got none required BusErr at cyc=%0d", mon_c);
         end
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ale_cyc(input logic [15:0] a);
      ale     = 1'b1;
      sys_bus = a;
      cur_addr = a[9:0];
      tick();
      ale     = 1'b0;
      sys_bus = 16'h0000;
   endtask

   // Issue a command in ADDR; the command edge is the next posedge (cyc+1).
   task automatic cmd_cyc(input bit r, input bit w, input logic [15:0] d);
      rd      = r;
      wr      = w;
      sys_bus = d;
      if (w)
         ram_m[cur_addr] = d;
      else
         exp_din = ram_m[cur_addr];
      rdy_q.push_back('{cyc + 1 + sel, exp_din});
      if (r && w)
         err_q.push_back(cyc + 1);
      tick();
      rd      = 1'b0;
      wr      = 1'b0;
      sys_bus = 16'h0000;
   endtask

   task automatic wait_done();
      repeat (sel) tick();
   endtask

   task automatic xfer(input logic [15:0] a, input bit r, input bit w, input logic [15:0] d);
      ale_cyc(a);
      cmd_cyc(r, w, d);
      wait_done();
      tick();
   endtask

   task automatic do_reset(input string name);
      #2;
      nreset = 1'b0;
      #1;
      check({name, "_datain"}, din_s, 16'h0000);
      check({name, "_memrdy"}, {15'h0, rdy_s}, 16'h0000);
      check({name, "_buserr"}, {15'h0, err_s}, 16'h0000);
      @(posedge clk);
      #3;
      nreset  = 1'b1;
      exp_din = 16'h0000;
      tick();
   endtask

   task automatic run_b2b();
      xfer(16'h0009, 1'b0, 1'b1, 16'h9999);
      xfer(16'h000A, 1'b0, 1'b1, 16'hAAAA);
      ale_cyc(16'h0009);
      cmd_cyc(1'b1, 1'b0, 16'h0000);
      wait_done();
      ale_cyc(16'h000A);
      cmd_cyc(1'b1, 1'b0, 16'h0000);
      wait_done();
      tick();
      ale_cyc(16'h0009);
      ale_cyc(16'h000A);
      cmd_cyc(1'b1, 1'b0, 16'h0000);
      wait_done();
      ale_cyc(16'h0009);
      cmd_cyc(1'b1, 1'b0, 16'h0000);
      wait_done();
      tick();
      check("b2b_hold", din_s, 16'h9999);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      mon_en   = 1'b0;
      sel      = 1;
      nreset   = 1'b0;
      sys_bus  = 16'h0000;
      ale      = 1'b0;
      rd       = 1'b0;
      wr       = 1'b0;
      exp_din  = 16'h0000;
      cur_addr = '0;
      repeat (2) tick();
      check("por_datain", din_s, 16'h0000);
      check("por_memrdy", {15'h0, rdy_s}, 16'h0000);
      check("por_buserr", {15'h0, err_s}, 16'h0000);
      #2;
      nreset = 1'b1;
      tick();
      mon_en = 1'b1;

      xfer(16'h0012, 1'b0, 1'b1, 16'hBEEF);
      xfer(16'h0012, 1'b1, 1'b0, 16'h0000);
      repeat (3) tick();
      check("read_hold", din_s, 16'hBEEF);

      do_reset("mid_reset");

      xfer(16'h0412, 1'b0, 1'b1, 16'h1234);
      xfer(16'h0012, 1'b1, 1'b0, 16'h0000);

      xfer(16'h0005, 1'b1, 1'b1, 16'h00AA);
      check("buserr_din_kept", din_s, 16'h1234);
      xfer(16'h0005, 1'b1, 1'b0, 16'h0000);

      xfer(16'h0007, 1'b0, 1'b1, 16'h1111);
      ale_cyc(16'h0007);
      rd      = 1'b0;
      wr      = 1'b1;
      sys_bus = 16'h5555;
      tick();
      wr      = 1'b0;
      sys_bus = 16'h0000;
      do_reset("abort_reset");
      repeat (3) tick();
      xfer(16'h0007, 1'b1, 1'b0, 16'h0000);

      do_reset("sel0_reset");
      sel = 0;
      run_b2b();

      do_reset("sel3_reset");
      sel = 3;
      run_b2b();

      repeat (4) tick();
      check("rdy_q_drained", 16'(rdy_q.size()), 16'h0000);
      check("err_q_drained", 16'(err_q.size()), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
